// File: rtl/cmul_pkg.sv
`default_nettype none
// ============================================================================
// cmul_pkg : shared types and product-index lookups for the complex sequencer
// Rev 1.0
// ============================================================================
package cmul_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      SETTLE = 3'd2,
      WAIT   = 3'd3,
      NEXT   = 3'd4,
      WRITE  = 3'd5
   } state_t;

   localparam logic [1:0] P_RR = 2'd0;
   localparam logic [1:0] P_II = 2'd1;
   localparam logic [1:0] P_RI = 2'd2;
   localparam logic [1:0] P_IR = 2'd3;

   // ai*bi is the only term that is subtracted
   function automatic logic prod_is_sub(input logic [1:0] k);
      return (k == P_II);
   endfunction

   function automatic logic prod_to_im(input logic [1:0] k);
      return (k == P_RI) || (k == P_IR);
   endfunction

   function automatic logic prod_a_is_re(input logic [1:0] k);
      return (k == P_RR) || (k == P_RI);
   endfunction

   function automatic logic prod_b_is_re(input logic [1:0] k);
      return (k == P_RR) || (k == P_IR);
   endfunction

endpackage
`default_nettype wire

// File: rtl/sm_to_twos.sv
`default_nettype none
// ============================================================================
// sm_to_twos : sign-magnitude to two's-complement converter, -0 maps to +0
// Rev 1.0
// ============================================================================
module sm_to_twos #(
   parameter int MAG_WIDTH = 14,
   parameter int OUT_WIDTH = 16
) (
   input  logic                 i_sign,
   input  logic [MAG_WIDTH-1:0] i_mag,
   output logic [OUT_WIDTH-1:0] o_value
);

   logic [OUT_WIDTH-1:0] w_ext;
   logic                 w_neg;

   always_comb begin
      w_ext   = OUT_WIDTH'(i_mag);
      w_neg   = i_sign && (|i_mag);
      o_value = w_neg ? (~w_ext + {{(OUT_WIDTH-1){1'b0}}, 1'b1}) : w_ext;
   end

endmodule
`default_nettype wire

// File: rtl/cmul_sequencer.sv
`default_nettype none
// ============================================================================
// cmul_sequencer : complex twiddle multiply through a shared serial multiplier
// Rev 1.0
// ============================================================================
module cmul_sequencer
   import cmul_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int OUT_WIDTH = 2*WIDTH
) (
   input  logic                   clkin,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIDTH-1:0]       ar,
   input  logic [WIDTH-1:0]       ai,
   input  logic [WIDTH-1:0]       br,
   input  logic [WIDTH-1:0]       bi,
   output logic [WIDTH-1:0]       mul_a,
   output logic [WIDTH-1:0]       mul_b,
   input  logic                   mul_ready,
   input  logic                   mul_sign,
   input  logic [2*WIDTH-3:0]     mul_product,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [OUT_WIDTH-1:0]   out_re,
   output logic [OUT_WIDTH-1:0]   out_im
);

   state_t               r_state;
   state_t               w_next_state;
   logic [1:0]           r_k;
   logic [WIDTH-1:0]     r_ar;
   logic [WIDTH-1:0]     r_ai;
   logic [WIDTH-1:0]     r_br;
   logic [WIDTH-1:0]     r_bi;
   logic [OUT_WIDTH-1:0] r_acc_re;
   logic [OUT_WIDTH-1:0] r_acc_im;

   logic [WIDTH-1:0]     w_op_a;
   logic [WIDTH-1:0]     w_op_b;
   logic                 w_bypass;
   logic                 w_write;
   logic [OUT_WIDTH-1:0] w_prod;

   sm_to_twos #(
      .MAG_WIDTH (2*WIDTH-2),
      .OUT_WIDTH (OUT_WIDTH)
   ) u_conv (
      .i_sign  (mul_sign),
      .i_mag   (mul_product),
      .o_value (w_prod)
   );

   assign w_op_a   = prod_a_is_re(r_k) ? r_ar : r_ai;
   assign w_op_b   = prod_b_is_re(r_k) ? r_br : r_bi;
   // a zero magnitude on either side makes the product zero whatever the sign
   assign w_bypass = ~(|w_op_a[WIDTH-2:0]) || ~(|w_op_b[WIDTH-2:0]);
   assign w_write  = (r_state == WRITE) && (!out_valid || out_ready);
   assign in_ready = (r_state == IDLE);

   always_ff @(posedge clkin or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (in_valid) w_next_state = LOAD;
         LOAD:    w_next_state = w_bypass ? NEXT : SETTLE;
         // the multiplier drops ready one edge after new operands, so skip a cycle
         SETTLE:  w_next_state = WAIT;
         WAIT:    if (mul_ready) w_next_state = NEXT;
         NEXT:    w_next_state = (r_k == P_IR) ? WRITE : LOAD;
         WRITE:   if (w_write) w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clkin or negedge rst_n) begin
      if (!rst_n) begin
         r_k      <= 2'd0;
         r_ar     <= '0;
         r_ai     <= '0;
         r_br     <= '0;
         r_bi     <= '0;
         r_acc_re <= '0;
         r_acc_im <= '0;
         mul_a    <= '0;
         mul_b    <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_ar     <= ar;
                  r_ai     <= ai;
                  r_br     <= br;
                  r_bi     <= bi;
                  r_acc_re <= '0;
                  r_acc_im <= '0;
                  r_k      <= 2'd0;
               end
            end
            LOAD: begin
               mul_a <= w_op_a;
               mul_b <= w_op_b;
            end
            WAIT: begin
               if (mul_ready) begin
                  if (prod_to_im(r_k)) begin
                     r_acc_im <= r_acc_im + w_prod;
                  end else if (prod_is_sub(r_k)) begin
                     r_acc_re <= r_acc_re - w_prod;
                  end else begin
                     r_acc_re <= r_acc_re + w_prod;
                  end
               end
            end
            NEXT: begin
               if (r_k != P_IR) r_k <= r_k + 2'd1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clkin or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_re    <= '0;
         out_im    <= '0;
      end else if (w_write) begin
         out_valid <= 1'b1;
         out_re    <= r_acc_re;
         out_im    <= r_acc_im;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cmul_sequencer.sv
`default_nettype none
// ============================================================================
// tb_cmul_sequencer : directed bench with a behavioural serial multiplier
// Rev 1.0
// ============================================================================
module tb_cmul_sequencer;

   localparam int WIDTH = 8;
   localparam int OW    = 2*WIDTH;

   logic            clkin = 1'b0;
   logic            rst_n;
   logic            in_valid;
   logic            in_ready;
   logic [WIDTH-1:0] ar, ai, br, bi;
   logic [WIDTH-1:0] mul_a, mul_b;
   logic            mul_ready;
   logic            mul_sign;
   logic [2*WIDTH-3:0] mul_product;
   logic            out_valid;
   logic            out_ready;
   logic [OW-1:0]   out_re, out_im;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clkin = ~clkin;

   cmul_sequencer #(.WIDTH(WIDTH)) dut (
      .clkin       (clkin),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .ar          (ar),
      .ai          (ai),
      .br          (br),
      .bi          (bi),
      .mul_a       (mul_a),
      .mul_b       (mul_b),
      .mul_ready   (mul_ready),
      .mul_sign    (mul_sign),
      .mul_product (mul_product),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_re      (out_re),
      .out_im      (out_im)
   );

   // Serial multiplier model: restarts on any operand change, drops ready on
   // the edge that sees the new operands, raises it WIDTH-1 edges later.
   logic [2*WIDTH-1:0] m_last = '0;
   int                 m_cnt  = 0;
   initial begin
      mul_ready   = 1'b0;
      mul_sign    = 1'b0;
      mul_product = '0;
   end
   always @(posedge clkin) begin
      if ({mul_a, mul_b} !== m_last) begin
         m_last    <= {mul_a, mul_b};
         mul_ready <= 1'b0;
         m_cnt     <= WIDTH-2;
      end else if (!mul_ready && m_cnt != 0) begin
         m_cnt <= m_cnt - 1;
      end else if (!mul_ready) begin
         mul_ready   <= 1'b1;
         mul_sign    <= mul_a[WIDTH-1] ^ mul_b[WIDTH-1];
         mul_product <= (2*WIDTH-2)'(mul_a[WIDTH-2:0]) * (2*WIDTH-2)'(mul_b[WIDTH-2:0]);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [WIDTH-1:0] a_r, a_i, b_r, b_i);
      int guard;
      guard = 0;
      @(negedge clkin);
      while (!in_ready && guard < 100) begin
         @(negedge clkin);
         guard++;
      end
      check("send_in_ready", {31'd0, in_ready}, 32'd1);
      ar = a_r; ai = a_i; br = b_r; bi = b_i;
      in_valid = 1'b1;
      @(negedge clkin);
      in_valid = 1'b0;
   endtask

   // cyc counts negedges after the accept edge until out_valid is seen
   task automatic wait_out(output int cyc, output int rdy_hi);
      cyc    = 1;
      rdy_hi = 0;
      while (!out_valid && cyc < 80) begin
         if (in_ready) rdy_hi++;
         @(negedge clkin);
         cyc++;
      end
      check("out_valid_seen", {31'd0, out_valid}, 32'd1);
   endtask

   int cyc, rdy_hi, cnt;
   logic stable;

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      ar = '0; ai = '0; br = '0; bi = '0;
      repeat (3) @(negedge clkin);
      check("rst_in_ready",  {31'd0, in_ready},  32'd1);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_re",    {16'd0, out_re},    32'd0);
      check("rst_out_im",    {16'd0, out_im},    32'd0);
      check("rst_mul_ab",    {16'd0, mul_a, mul_b}, 32'd0);
      rst_n = 1'b1;

      // Basic
      send(8'd3, 8'd4, 8'd2, 8'd1);
      wait_out(cyc, rdy_hi);
      check("basic_re", {16'd0, out_re}, 32'd2);
      check("basic_im", {16'd0, out_im}, 32'd11);
      check("basic_in_ready_low", rdy_hi, 0);
      check("basic_latency", {31'd0, cyc <= 4*(WIDTH+3)+2}, 32'd1);
      @(negedge clkin);
      check("basic_one_pulse", {31'd0, out_valid}, 32'd0);
      check("basic_idle", {31'd0, in_ready}, 32'd1);

      // Signs
      send(8'h85, 8'd2, 8'd3, 8'h87);
      wait_out(cyc, rdy_hi);
      check("signs_re", {16'd0, out_re}, 32'h0000FFFF);
      check("signs_im", {16'd0, out_im}, 32'd41);

      // Extremes
      send(8'd127, 8'hFF, 8'd127, 8'd127);
      wait_out(cyc, rdy_hi);
      check("ext_re", {16'd0, out_re}, 32'd32258);
      check("ext_im", {16'd0, out_im}, 32'd0);

      // Zero bypass incl. negative zero: P0 11 cycles, three bypasses 2 each
      send(8'd127, 8'h80, 8'd127, 8'd0);
      wait_out(cyc, rdy_hi);
      check("byp_re", {16'd0, out_re}, 32'd16129);
      check("byp_im", {16'd0, out_im}, 32'd0);
      check("byp_latency", cyc, 19);

      // Repeated operands: multiplier stays ready after P0
      send(8'd5, 8'd5, 8'd5, 8'd5);
      wait_out(cyc, rdy_hi);
      check("rep_re", {16'd0, out_re}, 32'd0);
      check("rep_im", {16'd0, out_im}, 32'd50);
      @(negedge clkin);

      // Backpressure across two operand sets
      out_ready = 1'b0;
      send(8'd3, 8'd4, 8'd2, 8'd1);
      wait_out(cyc, rdy_hi);
      check("bp_a_re", {16'd0, out_re}, 32'd2);
      check("bp_a_im", {16'd0, out_im}, 32'd11);
      send(8'h85, 8'd2, 8'd3, 8'h87);
      stable = 1'b1;
      for (int i = 0; i < 60; i++) begin
         if (out_re !== 16'd2 || out_im !== 16'd11 || out_valid !== 1'b1) stable = 1'b0;
         @(negedge clkin);
      end
      check("bp_a_stable", {31'd0, stable}, 32'd1);
      check("bp_b_stalled", {31'd0, in_ready}, 32'd0);
      out_ready = 1'b1;
      @(negedge clkin);
      check("bp_b_valid", {31'd0, out_valid}, 32'd1);
      check("bp_b_re", {16'd0, out_re}, 32'h0000FFFF);
      check("bp_b_im", {16'd0, out_im}, 32'd41);
      @(negedge clkin);
      check("bp_drained", {31'd0, out_valid}, 32'd0);

      // Reset while waiting on P2
      send(8'd3, 8'd4, 8'd2, 8'd1);
      repeat (27) @(negedge clkin);
      rst_n = 1'b0;
      #1;
      check("mid_rst_in_ready",  {31'd0, in_ready},  32'd1);
      check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("mid_rst_out",       {out_re, out_im},   32'd0);
      check("mid_rst_mul_ab",    {16'd0, mul_a, mul_b}, 32'd0);
      repeat (2) @(negedge clkin);
      rst_n = 1'b1;
      cnt = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clkin);
         if (out_valid) cnt++;
      end
      check("mid_rst_no_result", cnt, 0);
      check("mid_rst_idle", {31'd0, in_ready}, 32'd1);
      send(8'd1, 8'd1, 8'd1, 8'd1);
      wait_out(cyc, rdy_hi);
      check("post_rst_re", {16'd0, out_re}, 32'd0);
      check("post_rst_im", {16'd0, out_im}, 32'd2);

      @(negedge clkin);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/cmul_sequencer.md
Name: cmul_sequencer

Overview:
- Complex twiddle-multiply sequencer for the FFT datapath.
- Takes one complex sample and one twiddle, both sign-magnitude, and time-multiplexes the four real products through the existing serial shift-add multiplier.
- Consumes each sign/magnitude product from that multiplier, converts it to two's complement and accumulates it.
- Emits re = ar*br - ai*bi and im = ar*bi + ai*br to the butterfly stage over a valid/ready handshake.

Parameters:
- WIDTH, 8, sign-magnitude operand width: bit WIDTH-1 is the sign, bits WIDTH-2:0 are the magnitude. Must equal the multiplier's WIDTH.
- OUT_WIDTH, 2*WIDTH, two's-complement output width. Holds ±2*(2^(WIDTH-1)-1)^2 without overflow. Fixed; do not override.

Ports:
- clkin  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand set valid.
- in_ready  out  1  sequencer can accept an operand set.
- ar, ai  in  WIDTH each  sample real and imaginary parts, sign-magnitude.
- br, bi  in  WIDTH each  twiddle real and imaginary parts, sign-magnitude.
- mul_a, mul_b  out  WIDTH each  registered operands driven to the multiplier.
- mul_ready  in  1  multiplier done flag.
- mul_sign  in  1  multiplier sign output.
- mul_product  in  2*WIDTH-2  multiplier magnitude output.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_re, out_im  out  OUT_WIDTH each  two's-complement result.

Behaviour:
- Reset (asynchronous, active-low):
  - state=IDLE, k=0.
  - acc_re=acc_im=0, mul_a=mul_b=0.
  - out_valid=0, out_re=out_im=0.
  - in_ready follows state, so it is 1 after reset.
  - Reset mid-operation discards the operation. No result is emitted.
- in_ready = (state==IDLE), decoded from the state register.
- Product order for k=0..3:
  - P0 = ar*br, added to re.
  - P1 = ai*bi, subtracted from re.
  - P2 = ar*bi, added to im.
  - P3 = ai*br, added to im.
- IDLE:
  - On in_valid: latch ar/ai/br/bi, clear both accumulators, set k=0, go to LOAD.
- LOAD:
  - mul_a/mul_b <= pair k.
  - If either magnitude of pair k is 0 (zero bypass): product is 0 and sign is ignored. Go to NEXT without using the multiplier.
  - Otherwise go to SETTLE.
- SETTLE:
  - Exactly one cycle. mul_ready is ignored because the multiplier clears ready one edge after it sees new operands.
  - Go to WAIT.
- WAIT:
  - Hold mul_a/mul_b stable.
  - When mul_ready=1: signed value = mul_sign ? -mul_product : +mul_product, zero-extended to OUT_WIDTH before negation.
  - Add or subtract the value into the accumulator selected by k, then go to NEXT.
  - If pair k's operands equal the previously issued pair, the multiplier does not restart. Its ready stays 1 and its product is still correct, so WAIT completes on the first cycle. This is the required behaviour.
- NEXT:
  - If k==3 go to WRITE; else k<=k+1 and go to LOAD.
- WRITE:
  - If out_valid==0 or out_ready==1: out_re<=acc_re, out_im<=acc_im, out_valid<=1, go to IDLE.
  - Otherwise stall in WRITE.
- out_valid:
  - Cleared on out_valid & out_ready, unless WRITE loads in the same cycle; then it stays 1.
  - Once asserted, out_re/out_im are stable until accepted.
- Negative zero (sign=1, magnitude=0) on any input is treated as +0.
- After reset the multiplier's ready may be X until its first restart. Zero bypass means the operands stay 0, so the sequencer only waits on mul_ready after issuing a nonzero operand pair.
- Latency:
  - Per multiplied pair: at most WIDTH+3 cycles.
  - Per bypassed pair: 2 cycles.
  - Input accept to out_valid with no backpressure: at most 4*(WIDTH+3)+2 cycles.
- Arithmetic:
  - Accumulators are OUT_WIDTH two's complement.
  - Overflow is impossible by width choice. No saturation logic.

Decomposition:
- Package cmul_pkg holds:
  - state enum: IDLE, LOAD, SETTLE, WAIT, NEXT, WRITE;
  - product index constants P_RR=0, P_II=1, P_RI=2, P_IR=3;
  - per-index add/subtract and target (re/im) lookup.
- One sub-module: sm_to_twos, a combinational sign-magnitude to two's-complement converter with a zero-sign clear. It is reused by downstream stages.
- The multiplier is instantiated beside this block at the top level, not inside it.

Test Plan:
- WIDTH=8 for all scenarios. Negative inputs are given as the decimal value with the sign-magnitude encoding in brackets.
- Basic: ar=3, ai=4, br=2, bi=1 -> out_re=2, out_im=11, one out_valid pulse, in_ready low throughout.
- Signs: ar=-5 (0x85), ai=2, br=3, bi=-7 (0x87) -> out_re=-1 (0xFFFF), out_im=41.
- Extremes and zero bypass:
  - ar=127, ai=-127 (0xFF), br=127, bi=127 -> out_re=32258, out_im=0.
  - ar=127, ai=0x80, br=127, bi=0 -> out_re=16129, out_im=0; P1, P2 and P3 each bypass in 2 cycles.
- Repeated operands: ar=ai=br=bi=5 (multiplier never restarts after P0) -> out_re=0, out_im=50, no hang in WAIT.
- Backpressure: hold out_ready=0 across two operand sets -> first result held stable, second set stalls in WRITE; releasing out_ready delivers both in order with no loss.
- Reset mid-WAIT: assert rst_n=0 during P2 -> all outputs at reset values, in_ready=1 after release. The next set ar=1, ai=1, br=1, bi=1 gives out_re=0, out_im=2.
